// File: rtl/snn_mem_pkg.sv
// Shared definitions for the SNN weight-memory path.
//   load_state_t    : loader FSM states (IDLE, LOAD, DONE)
//   chunks_per_word : number of stream chunks that make up one memory word
package snn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    function automatic int chunks_per_word(input int fp_width, input int in_width);
        return fp_width / in_width;
    endfunction

endpackage

// File: rtl/chunk_packer.sv
// Assembles IN_WIDTH stream chunks into one FIXED_POINT_WIDTH word,
// little-endian: the first accepted chunk lands in the lowest bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous discard of any partial word
//   accept     : a chunk is being taken this cycle (valid & ready)
//   s_data     : the chunk
//   word_done  : this accept completes a word (combinational)
//   word       : the assembled word including the current chunk (valid with word_done)
module chunk_packer
    import snn_mem_pkg::*;
#(
    parameter int FIXED_POINT_WIDTH = 32,
    parameter int IN_WIDTH          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         accept,
    input  logic [IN_WIDTH-1:0]          s_data,
    output logic                         word_done,
    output logic [FIXED_POINT_WIDTH-1:0] word
);

    localparam int CHUNKS = chunks_per_word(FIXED_POINT_WIDTH, IN_WIDTH);
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

    logic [FIXED_POINT_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]             cnt;

    // New chunk enters at the top and older chunks move down, so after
    // CHUNKS accepts the first chunk sits in the low bits.
    always_comb begin
        word      = FIXED_POINT_WIDTH'({s_data, shreg} >> IN_WIDTH);
        word_done = accept && (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= word;
            cnt   <= word_done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams weight words into a BRAM: captures a base address and word count on
// start, packs incoming chunks into words and writes them to consecutive
// addresses, then pulses done.
//   start/base_addr/num_words : load request (sampled in IDLE only)
//   s_valid/s_data/s_last/s_ready : chunk stream; a chunk moves when
//       s_valid and s_ready are both high at a rising clk edge. s_ready is
//       high only in LOAD; s_valid may drop for any number of cycles.
//   bram_we/bram_waddr/bram_wdata : one-cycle write strobe, address, data
//   busy/done/err : load active, one-cycle completion pulse, sticky error
//   dbg_state     : current FSM state
module weight_loader
    import snn_mem_pkg::*;
#(
    parameter int BRAM_DEPTH        = 32,
    parameter int BRAM_ADDR_WIDTH   = 10,
    parameter int FIXED_POINT_WIDTH = 32,
    parameter int IN_WIDTH          = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [BRAM_ADDR_WIDTH-1:0]          base_addr,
    input  logic [BRAM_ADDR_WIDTH:0]            num_words,
    input  logic                                s_valid,
    input  logic [IN_WIDTH-1:0]                 s_data,
    input  logic                                s_last,
    output logic                                s_ready,
    output logic                                bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]          bram_waddr,
    output logic signed [FIXED_POINT_WIDTH-1:0] bram_wdata,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic [1:0]                          dbg_state
);

    localparam logic [BRAM_ADDR_WIDTH+1:0] DEPTH_L = (BRAM_ADDR_WIDTH + 2)'(BRAM_DEPTH);

    load_state_t                  state;
    logic [BRAM_ADDR_WIDTH-1:0]   base_q;
    logic [BRAM_ADDR_WIDTH:0]     num_q;
    logic [BRAM_ADDR_WIDTH:0]     word_idx;
    logic [BRAM_ADDR_WIDTH+1:0]   end_addr;
    logic                         range_bad;
    logic                         accept;
    logic                         last_word;
    logic                         word_done;
    logic [FIXED_POINT_WIDTH-1:0] packed_word;

    assign end_addr  = {2'b00, base_addr} + {1'b0, num_words};
    assign range_bad = (end_addr > DEPTH_L);
    assign accept    = s_valid && s_ready;
    assign last_word = (word_idx == num_q - (BRAM_ADDR_WIDTH + 1)'(1));
    assign dbg_state = state;

    // Packer is held clear outside LOAD so an aborted partial word never
    // leaks into the next load.
    chunk_packer #(
        .FIXED_POINT_WIDTH (FIXED_POINT_WIDTH),
        .IN_WIDTH          (IN_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state != LOAD),
        .accept    (accept),
        .s_data    (s_data),
        .word_done (word_done),
        .word      (packed_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bram_we    <= 1'b0;
            bram_waddr <= '0;
            bram_wdata <= '0;
            base_q     <= '0;
            num_q      <= '0;
            word_idx   <= '0;
        end else begin
            bram_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= range_bad;
                        busy     <= 1'b1;
                        base_q   <= base_addr;
                        num_q    <= num_words;
                        word_idx <= '0;
                        // Rejected and empty loads skip LOAD entirely.
                        if (range_bad || (num_words == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (word_done && last_word) begin
                            // Final word is written even if s_last is missing.
                            bram_we    <= 1'b1;
                            bram_waddr <= base_q + word_idx[BRAM_ADDR_WIDTH-1:0];
                            bram_wdata <= packed_word;
                            state      <= DONE;
                            done       <= 1'b1;
                            s_ready    <= 1'b0;
                            if (!s_last) err <= 1'b1;
                        end else if (s_last) begin
                            // Early s_last: drop the current word, no write.
                            err     <= 1'b1;
                            state   <= DONE;
                            done    <= 1'b1;
                            s_ready <= 1'b0;
                        end else if (word_done) begin
                            bram_we    <= 1'b1;
                            bram_waddr <= base_q + word_idx[BRAM_ADDR_WIDTH-1:0];
                            bram_wdata <= packed_word;
                            word_idx   <= word_idx + (BRAM_ADDR_WIDTH + 1)'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 10;
  localparam int FW    = 32;
  localparam int IW    = 8;
  localparam int CH    = FW / IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW:0]          num_words = '0;
  logic                 s_valid = 1'b0;
  logic [IW-1:0]        s_data = '0;
  logic                 s_last = 1'b0;
  logic                 s_ready;
  logic                 bram_we;
  logic [AW-1:0]        bram_waddr;
  logic signed [FW-1:0] bram_wdata;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [1:0]           dbg_state;

  weight_loader #(
    .BRAM_DEPTH        (DEPTH),
    .BRAM_ADDR_WIDTH   (AW),
    .FIXED_POINT_WIDTH (FW),
    .IN_WIDTH          (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .bram_we    (bram_we),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+FW-1:0] exp_q[$];   // expected writes {addr, data}
  logic [AW+FW-1:0] wr_log[$];  // observed writes
  logic [IW-1:0]    chk_q[$];   // chunks for the current load
  logic             exp_err = 1'b0;
  logic             exp_with_write = 1'b0;
  logic             exp_done_pending = 1'b0;
  int               done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Given the chunk list, the s_last position (-1 = never) and the request,
  // compute the writes, final err and whether done coincides with a write.
  task automatic build_expect(input int base, input int num, input int last_pos);
    int total;
    int n_wr;
    logic [FW-1:0] w;
    total = num * CH;
    exp_q.delete();
    if (base + num > DEPTH) begin
      exp_err = 1'b1; exp_with_write = 1'b0; return;
    end
    if (num == 0) begin
      exp_err = 1'b0; exp_with_write = 1'b0; return;
    end
    if (last_pos >= 0 && last_pos < total - 1) begin
      n_wr = (last_pos + 1) / CH;
      // s_last on a word's final chunk still discards that word
      if ((last_pos + 1) % CH == 0) n_wr = n_wr - 1;
      exp_err = 1'b1; exp_with_write = 1'b0;
    end else begin
      n_wr = num;
      exp_err = (last_pos != total - 1);
      exp_with_write = 1'b1;
    end
    for (int wi = 0; wi < n_wr; wi++) begin
      w = '0;
      for (int k = 0; k < CH; k++) w = w | (FW'(chk_q[wi*CH + k]) << (k*IW));
      exp_q.push_back({AW'(base + wi), w});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_we) begin
        wr_log.push_back({bram_waddr, bram_wdata});
        if (exp_q.size() == 0) begin
          check("unexpected_write", {22'd0, bram_waddr, bram_wdata}, 64'd0);
        end else begin
          check("write", {22'd0, bram_waddr, bram_wdata}, {22'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        check("done_expected", 64'(exp_done_pending), 64'd1);
        check("done_writes_all", 64'(exp_q.size()), 64'd0);
        check("done_err", 64'(err), 64'(exp_err));
        check("done_with_last_write", 64'(bram_we), 64'(exp_with_write));
        exp_done_pending = 1'b0;
      end
      if (dbg_state != 2'd1) check("s_ready_outside_load", 64'(s_ready), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_chunk(input logic [IW-1:0] d, input logic last);
    logic acc;
    int t;
    s_valid = 1'b1; s_data = d; s_last = last;
    acc = 1'b0; t = 0;
    while (!acc && t < 50) begin
      acc = s_ready;
      @(negedge clk);
      t++;
    end
    if (!acc) check("chunk_timeout", 64'd0, 64'd1);
  endtask

  task automatic fill_random(input int n);
    chk_q.delete();
    for (int i = 0; i < n; i++) chk_q.push_back(IW'($urandom_range(0, 255)));
  endtask

  // Called aligned to a negedge. chk_q must hold enough chunks.
  task automatic run_load(input int base, input int num, input int last_pos,
                          input int gap_max, input bit alt_gap, input bit inject);
    int n_send;
    int gap;
    int d0;
    int t;
    logic reject;
    reject = (base + num > DEPTH) || (num == 0);
    n_send = reject ? 0 : ((last_pos >= 0) ? last_pos + 1 : num * CH);
    build_expect(base, num, last_pos);
    exp_done_pending = 1'b1;
    d0 = done_cnt;
    start = 1'b1; base_addr = AW'(base); num_words = (AW+1)'(num);
    @(negedge clk);
    start = 1'b0;
    check("err_on_start", 64'(err), 64'(base + num > DEPTH));
    if (reject) check("done_after_start", 64'(done), 64'd1);
    else        check("load_entry", {62'd0, s_ready, busy}, 64'd3);
    for (int i = 0; i < n_send; i++) begin
      gap = alt_gap ? 1 : $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0; s_last = 1'b0;
        if (inject && i == 1 && g == 0) begin
          start = 1'b1; base_addr = '0; num_words = (AW+1)'(1);
        end
        @(negedge clk);
        start = 1'b0;
      end
      send_chunk(chk_q[i], (i == last_pos));
    end
    s_valid = 1'b0; s_last = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int num;
    int mode;
    int total;
    int lp;

    #23;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_bram_we", 64'(bram_we), 64'd0);
    check("rst_waddr", 64'(bram_waddr), 64'd0);
    check("rst_wdata", 64'(bram_wdata), 64'd0);
    check("rst_busy_done_err", {61'd0, busy, done, err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first start on the first edge after reset release
    chk_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wr_log.delete();
    run_load(4, 2, 7, 0, 1'b0, 1'b0);
    check("t1_nwrites", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      check("t1_w0", 64'(wr_log[0]), {22'd0, 10'd4, 32'h44332211});
      check("t1_w1", 64'(wr_log[1]), {22'd0, 10'd5, 32'h88776655});
    end
    check("t1_err", 64'(err), 64'd0);

    // same load, s_valid low every other cycle
    wr_log.delete();
    run_load(4, 2, 7, 0, 1'b1, 1'b0);
    check("t2_nwrites", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      check("t2_w0", 64'(wr_log[0]), {22'd0, 10'd4, 32'h44332211});
      check("t2_w1", 64'(wr_log[1]), {22'd0, 10'd5, 32'h88776655});
    end

    // out-of-range request
    wr_log.delete();
    run_load(30, 3, -1, 0, 1'b0, 1'b0);
    check("t3_nwrites", 64'(wr_log.size()), 64'd0);
    check("t3_err", 64'(err), 64'd1);

    // empty request clears err
    run_load(0, 0, -1, 0, 1'b0, 1'b0);
    check("t4_err", 64'(err), 64'd0);

    // s_last on second chunk of a one-word load
    fill_random(4);
    wr_log.delete();
    run_load(7, 1, 1, 2, 1'b0, 1'b0);
    check("t5_nwrites", 64'(wr_log.size()), 64'd0);
    check("t5_err", 64'(err), 64'd1);

    // next valid load clears err; start pulsed mid-load is ignored
    fill_random(12);
    wr_log.delete();
    run_load(10, 3, 11, 3, 1'b0, 1'b1);
    check("t6_nwrites", 64'(wr_log.size()), 64'd3);
    check("t6_err", 64'(err), 64'd0);

    // reset after two chunks of a word
    exp_q.delete();
    exp_done_pending = 1'b0;
    start = 1'b1; base_addr = AW'(8); num_words = (AW+1)'(2);
    @(negedge clk);
    start = 1'b0;
    send_chunk(8'h5A, 1'b0);
    send_chunk(8'hA5, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_we_busy_done_err", {60'd0, bram_we, busy, done, err}, 64'd0);
    check("mid_rst_waddr_wdata", {22'd0, bram_waddr, bram_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    wr_log.delete();
    run_load(8, 1, 3, 1, 1'b0, 1'b0);
    check("t7_nwrites", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() == 1) check("t7_w0", 64'(wr_log[0]), {22'd0, 10'd8, 32'hD4C3B2A1});

    // randomized loads
    for (int r = 0; r < 40; r++) begin
      base = $urandom_range(0, 31);
      num  = $urandom_range(0, 6);
      mode = $urandom_range(0, 9);
      total = num * CH;
      lp = total - 1;
      if (mode == 0 && total > 1) lp = $urandom_range(0, total - 2);
      else if (mode == 1 && total > 0) lp = -1;
      if (total == 0) lp = -1;
      fill_random(total);
      run_load(base, num, lp, 3, 1'b0, (mode == 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 32: number of words in the target weight memory.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH, default 10: write address width.
REQ-003 SHALL have parameter FIXED_POINT_WIDTH, default 32: signed weight word width.
REQ-004 SHALL have parameter IN_WIDTH, default 8: stream chunk width; FIXED_POINT_WIDTH SHALL be an integer multiple of IN_WIDTH.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle load request, sampled in IDLE only.
REQ-008 SHALL have port base_addr  input  BRAM_ADDR_WIDTH  first write address, captured with start.
REQ-009 SHALL have port num_words  input  BRAM_ADDR_WIDTH+1  words to load, captured with start.
REQ-010 SHALL have port s_valid  input  1  stream chunk valid.
REQ-011 SHALL have port s_data  input  IN_WIDTH  stream chunk.
REQ-012 SHALL have port s_last  input  1  marks final chunk of the load.
REQ-013 SHALL have port s_ready  output  1  chunk accepted when s_valid and s_ready are both high.
REQ-014 SHALL have port bram_we  output  1  write strobe to weight memory.
REQ-015 SHALL have port bram_waddr  output  BRAM_ADDR_WIDTH  write address.
REQ-016 SHALL have port bram_wdata  output  FIXED_POINT_WIDTH  signed write data.
REQ-017 SHALL have port busy / done / err  output  1 each  load active / one-cycle completion pulse / sticky error.

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE; IDLE->LOAD on start with valid range and num_words>0; LOAD->DONE after final word written or on abort; DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL drive s_ready=1 only in LOAD, and busy=1 in LOAD and DONE.
REQ-020 SHALL pack CHUNKS=FIXED_POINT_WIDTH/IN_WIDTH chunks per word little-endian: first accepted chunk into bits [IN_WIDTH-1:0].
REQ-021 SHALL assert bram_we for exactly one cycle, the cycle after the final chunk of each word is accepted, with bram_waddr=base_addr+word_index and bram_wdata registered.
REQ-022 SHALL keep bram_we=0 at all other times; bram_waddr/bram_wdata hold last values.
REQ-023 SHALL assert done for exactly one cycle in DONE; the last bram_we of a load occurs in the same cycle as done.
REQ-024 SHALL treat start with num_words=0 as IDLE->DONE: no writes, done pulse next cycle, err=0.
REQ-025 SHALL reject start when base_addr+num_words>BRAM_DEPTH: err=1, no writes, IDLE->DONE.
REQ-026 SHALL, on s_last accepted on any chunk other than the final chunk of the final word, set err, discard the partial word, skip the write, and go to DONE.
REQ-027 SHALL, when the final chunk of the final word is accepted without s_last, set err but still write that word and finish normally.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL clear err only on an accepted start; err persists through DONE and IDLE.
REQ-030 SHALL tolerate s_valid gaps of any length without altering packing or addresses.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-load, asynchronously force state IDLE, s_ready=0, bram_we=0, bram_waddr=0, bram_wdata=0, busy=0, done=0, err=0, and discard any partial word.
REQ-032 SHALL accept a start on the first clock edge after rst_n deasserts.

Structure
REQ-033 SHALL take the state enum and a CHUNKS constant function from shared package snn_mem_pkg.
REQ-034 SHALL place chunk assembly (shift register + chunk counter, word-complete flag) in one sub-module, chunk_packer; FSM and address counter stay in weight_loader.

Verification
REQ-035 SHALL cover: start, base_addr=4, num_words=2; chunks 11,22,33,44,55,66,77,88 (s_last on 88) -> writes 0x44332211 @4, 0x88776655 @5, done with second write, err=0.
REQ-036 SHALL cover: same load with s_valid low on alternate cycles -> identical writes and values, done after last write.
REQ-037 SHALL cover: base_addr=30, num_words=3 (BRAM_DEPTH=32) -> no bram_we, err=1, done one cycle after start.
REQ-038 SHALL cover: num_words=1, s_last on second chunk -> no write, err=1, done pulse; next valid start clears err.
REQ-039 SHALL cover: rst_n low after 2 chunks of a word -> all outputs 0 asynchronously; fresh load after release writes correct data at base_addr.
REQ-040 SHALL cover: start pulsed during LOAD -> ignored, original load completes unchanged.
